// File: rtl/irq_pkg.sv
// Shared types and constants for the external interrupt controller.
package irq_pkg;

  // Request handshake states toward the core.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } irq_state_t;

  // ESR code the core reports for an external interrupt; shared with the core controller.
  localparam logic [3:0] ESTATUS_EXT_IRQ = 4'b0001;

endpackage : irq_pkg

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of req (index 0 wins).
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int IDW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0] req,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    idx = '0;
    any = |req;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = IDW'(i);
    end
  end

endmodule : irq_prio_enc

// File: rtl/irq_controller.sv
// External interrupt controller: edge capture, pending/lost tracking, fixed-priority
// arbitration and the four-phase ExtIRQ / ExtlAck handshake toward the core.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int IDW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSRC-1:0] irq_src,
  input  logic [NSRC-1:0] irq_mask,
  input  logic            ExtlAck,
  output logic            ExtIRQ,
  output logic [IDW-1:0]  irq_id,
  output logic [NSRC-1:0] irq_pending,
  output logic [NSRC-1:0] irq_lost,
  output logic [NSRC-1:0] src_ack
);

  irq_state_t      state_q, state_d;
  logic            armed_q;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] lost_q, lost_d;
  logic [NSRC-1:0] src_ack_q, src_ack_d;
  logic            ext_irq_q, ext_irq_d;
  logic [IDW-1:0]  irq_id_q, irq_id_d;

  logic [NSRC-1:0] src_edge;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] retire;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;

  // Lowest-index unmasked pending source; only consulted while IDLE.
  irq_prio_enc #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_prio_enc (
    .req (eligible),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Edge detect and retire decode. Edges are ignored on the first clock after reset,
  // while src_q is still zero, so a line that is already high at release is not a request.
  always_comb begin
    src_edge = armed_q ? (irq_src & ~src_q) : '0;
    eligible = pending_q & ~irq_mask;
    retire   = '0;
    for (int i = 0; i < NSRC; i++) begin
      retire[i] = (state_q == REQ) && ExtlAck && (irq_id_q == IDW'(i));
    end
  end

  // Pending/lost bookkeeping: a new edge beats the retire of the same source.
  always_comb begin
    pending_d = (pending_q & ~retire) | src_edge;
    lost_d    = (lost_q & ~retire) | (src_edge & pending_q & ~retire);
    src_ack_d = retire;
  end

  // Next-state logic of the request handshake; irq_id is latched only on IDLE -> REQ.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d  = REQ;
          irq_id_d = arb_idx;
        end
      end
      REQ: begin
        if (ExtlAck) state_d = RELEASE;
      end
      RELEASE: begin
        if (!ExtlAck) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ext_irq_d = (state_d == REQ);
  end

  // All state and registered outputs; reset clears everything, including mid-request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      src_q     <= '0;
      pending_q <= '0;
      lost_q    <= '0;
      src_ack_q <= '0;
      ext_irq_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      armed_q   <= 1'b1;
      src_q     <= irq_src;
      pending_q <= pending_d;
      lost_q    <= lost_d;
      src_ack_q <= src_ack_d;
      ext_irq_q <= ext_irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign ExtIRQ      = ext_irq_q;
  assign irq_id      = irq_id_q;
  assign irq_pending = pending_q;
  assign irq_lost    = lost_q;
  assign src_ack     = src_ack_q;

endmodule : irq_controller

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller with a queue of expected service order.
module tb_irq_controller;

  localparam int NSRC = 4;
  localparam int IDW  = 2;

  logic            clk;
  logic            reset_n;
  logic [NSRC-1:0] irq_src;
  logic [NSRC-1:0] irq_mask;
  logic            ExtlAck;
  logic            ExtIRQ;
  logic [IDW-1:0]  irq_id;
  logic [NSRC-1:0] irq_pending;
  logic [NSRC-1:0] irq_lost;
  logic [NSRC-1:0] src_ack;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  irq_controller #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .irq_src     (irq_src),
    .irq_mask    (irq_mask),
    .ExtlAck     (ExtlAck),
    .ExtIRQ      (ExtIRQ),
    .irq_id      (irq_id),
    .irq_pending (irq_pending),
    .irq_lost    (irq_lost),
    .src_ack     (src_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait for ExtIRQ to rise.
  task automatic wait_irq(input string tag);
    int n = 0;
    while (ExtIRQ !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, ExtIRQ, 1);
  endtask

  // Serve the current request: compare irq_id with the scoreboard, hold ExtlAck for
  // ack_cycles cycles, check the single src_ack pulse and that ExtIRQ stays low.
  task automatic serve(input string tag, input int ack_cycles);
    int exp_id;
    logic [NSRC-1:0] onehot;
    check({tag, "_sb"}, exp_q.size() != 0, 1);
    exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
    onehot = '0;
    onehot[exp_id] = 1'b1;
    check({tag, "_id"}, irq_id, exp_id);
    ExtlAck = 1'b1;
    for (int c = 0; c < ack_cycles; c++) begin
      tick();
      check({tag, "_ack"}, src_ack, (c == 0) ? onehot : '0);
      check({tag, "_irq_low"}, ExtIRQ, 0);
    end
    ExtlAck = 1'b0;
    tick();
    check({tag, "_rel"}, ExtIRQ, 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    irq_src  = '0;
    irq_mask = '0;
    ExtlAck  = 1'b0;
    #2;
    check("rst_irq", ExtIRQ, 0);
    check("rst_id", irq_id, 0);
    check("rst_pend", irq_pending, 0);
    check("rst_lost", irq_lost, 0);
    check("rst_ack", src_ack, 0);
    tick();
    reset_n = 1'b1;
    ticks(2);
    check("idle_irq", ExtIRQ, 0);

    // Single request: source 2 rises in cycle 0, ExtIRQ high in cycle 2.
    irq_src[2] = 1'b1;
    exp_q.push_back(2);
    tick();
    check("single_pend", irq_pending, 4'b0100);
    check("single_irq_c1", ExtIRQ, 0);
    tick();
    check("single_irq_c2", ExtIRQ, 1);
    serve("single", 3);
    check("single_pend_clr", irq_pending, 0);
    irq_src = '0;
    ticks(2);

    // Priority: sources 1 and 3 together, 1 first, then 3 with a 2-cycle low gap.
    irq_src = 4'b1010;
    exp_q.push_back(1);
    exp_q.push_back(3);
    ticks(2);
    check("prio_irq", ExtIRQ, 1);
    serve("prio1", 1);
    tick();
    check("prio_b2b", ExtIRQ, 1);
    serve("prio3", 2);
    irq_src = '0;
    ticks(2);

    // Masking: source 1 masked, 3 served first, 1 stays pending until unmasked.
    irq_mask = 4'b0010;
    irq_src  = 4'b1010;
    exp_q.push_back(3);
    wait_irq("mask_wait3");
    serve("mask3", 1);
    ticks(3);
    check("mask_hold_irq", ExtIRQ, 0);
    check("mask_pend1", irq_pending, 4'b0010);
    irq_mask = '0;
    exp_q.push_back(1);
    wait_irq("mask_wait1");
    serve("mask1", 1);
    check("mask_pend_clr", irq_pending, 0);
    irq_src = '0;
    ticks(2);

    // Mask raised during REQ does not retract or change the request.
    irq_src[0] = 1'b1;
    exp_q.push_back(0);
    wait_irq("mreq_wait");
    irq_mask = 4'b0001;
    ticks(2);
    check("mreq_irq", ExtIRQ, 1);
    check("mreq_id", irq_id, 0);
    serve("mreq", 1);
    irq_mask = '0;
    irq_src  = '0;
    ticks(2);

    // Collision: edge on source 0 in its own retire cycle keeps it pending.
    irq_src[0] = 1'b1;
    exp_q.push_back(0);
    wait_irq("col_wait");
    irq_src[0] = 1'b0;
    tick();
    check("col_id", irq_id, 0);
    irq_src[0] = 1'b1;
    ExtlAck = 1'b1;
    void'(exp_q.pop_front());
    tick();
    check("col_ack", src_ack, 4'b0001);
    check("col_pend", irq_pending, 4'b0001);
    check("col_lost0", irq_lost, 0);
    check("col_irq_low", ExtIRQ, 0);
    ExtlAck = 1'b0;
    exp_q.push_back(0);
    wait_irq("col_wait2");
    irq_src[0] = 1'b0;
    tick();
    irq_src[0] = 1'b1;
    tick();
    check("col_lost1", irq_lost, 4'b0001);
    serve("col2", 1);
    check("col_lost_clr", irq_lost, 0);
    check("col_pend_clr", irq_pending, 0);
    irq_src = '0;
    ticks(2);

    // Reset mid-request with source 1 held high.
    irq_src[1] = 1'b1;
    wait_irq("rmid_wait");
    #2;
    reset_n = 1'b0;
    #1;
    check("rmid_irq", ExtIRQ, 0);
    check("rmid_id", irq_id, 0);
    check("rmid_pend", irq_pending, 0);
    check("rmid_lost", irq_lost, 0);
    check("rmid_ack", src_ack, 0);
    tick();
    reset_n = 1'b1;
    ticks(4);
    check("rmid_no_edge_pend", irq_pending, 0);
    check("rmid_no_edge_irq", ExtIRQ, 0);
    irq_src[1] = 1'b0;
    tick();
    irq_src[1] = 1'b1;
    exp_q.push_back(1);
    wait_irq("rmid_wait2");
    serve("rmid", 1);
    check("rmid_pend_clr", irq_pending, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_irq_controller

// File: doc/irq_controller.md
# irq_controller

External interrupt controller at the requesting end of the core's ExtIRQ / ExtlAck handshake. Captures rising edges on up to NSRC device request lines and holds them as pending bits. Selects the lowest-numbered unmasked pending source, raises ExtIRQ toward the core and holds it until the core's controller answers with ExtlAck. Then it retires that source, pulses a per-source acknowledge back to the device, and re-arbitrates.

## Interface
- NSRC, 4: number of interrupt sources, 1..16.
- IDW, $clog2(NSRC) (min 1): width of irq_id.
- clk  in  1  core clock; all inputs synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- irq_src  in  NSRC  device request lines; a 0→1 transition is one request.
- irq_mask  in  NSRC  1 = source masked (excluded from arbitration; pending still recorded).
- ExtlAck  in  1  acknowledge from the core controller (ExcAck & ExtIRQ on that side).
- ExtIRQ  out  1  interrupt request to the core, registered.
- irq_id  out  IDW  index of the source being requested; valid while ExtIRQ = 1, frozen for the whole request.
- irq_pending  out  NSRC  current pending bits.
- irq_lost  out  NSRC  sticky: a second edge arrived while that source was already pending.
- src_ack  out  NSRC  one-hot, one-cycle pulse to the retired source.

## Operation
- Edge detect: src_q <= irq_src every cycle; edge = irq_src & ~src_q.
- Pending: pending[i] set on edge[i]. It is cleared only in the retire cycle of source i.
  - If edge[i] coincides with the retire of i, set wins and pending[i] stays 1.
- Lost: irq_lost[i] set when edge[i] arrives with pending[i] = 1 and no retire of i in that cycle. It is cleared in the retire cycle of i unless set again in that same cycle.
- FSM, encoded as irq_state_t:
  - IDLE: ExtIRQ = 0. If |(pending & ~irq_mask), latch irq_id = lowest such index and go to REQ.
  - REQ: ExtIRQ = 1, irq_id frozen. Mask changes and new edges do not retract or change the request. On ExtlAck = 1: clear pending[irq_id], pulse src_ack[irq_id] and go to RELEASE.
  - RELEASE: ExtIRQ = 0. Stay while ExtlAck = 1, which completes the four-phase handshake. On ExtlAck = 0, go to IDLE.
- ExtlAck in IDLE or RELEASE without a matching request has no effect on the pending bits.
- Arbitration is fixed priority (index 0 highest) and happens only in IDLE.
- Reset, asynchronous, including mid-request:
  - state = IDLE, src_q = 0, pending = 0, irq_lost = 0, irq_id = 0, ExtIRQ = 0, src_ack = 0.
  - A line already high at reset release does not count as an edge until it falls and rises again, because src_q captures it on the first clock.

## Timing
- Request latency, with the source unmasked and the FSM in IDLE:
  - irq_src rises in cycle 0.
  - pending is set at edge 1.
  - REQ is entered at edge 2, so ExtIRQ is high in cycle 2.
- Retire: ExtlAck is high in cycle k while in REQ.
  - At edge k+1: ExtIRQ drops, pending clears, src_ack is high for cycle k+1.
- Back-to-back service:
  - ExtlAck low in cycle k+1 → IDLE at edge k+2 → next ExtIRQ in cycle k+3.
  - Minimum gap with ExtIRQ low between two requests: 2 cycles.
- All outputs are registered; none depends combinationally on inputs.

## Structure
- Package irq_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, RELEASE} irq_state_t
  - localparam ESTATUS_EXT_IRQ = 4'b0001, the ESR code the core reports for this exception, shared with the core controller.
- One sub-module, irq_prio_enc: combinational lowest-index priority encoder (NSRC → IDW + any-valid). Everything else stays in irq_controller.

## Test plan
- Single request: NSRC = 4, pulse irq_src[2] at cycle 0 → ExtIRQ = 1 and irq_id = 2 in cycle 2. ExtlAck held 1 for 3 cycles → src_ack = 4'b0100 for exactly one cycle, pending = 0, ExtIRQ stays 0 until ExtlAck falls.
- Priority and masking: edges on sources 1 and 3 in the same cycle → irq_id = 1 first, then 3. With irq_mask[1] = 1 → source 3 is served first and pending[1] remains 1.
- Mask during REQ: raise mask of the requested source while ExtIRQ = 1 → ExtIRQ and irq_id unchanged until ExtlAck.
- Collision: edge on source 0 in the retire cycle of source 0 → pending[0] stays 1 and a second request follows. A third edge while pending → irq_lost[0] = 1, cleared at its next retire.
- Reset mid-request: assert reset_n = 0 while in REQ with irq_src[1] held high → all outputs 0 immediately. After release, no request until irq_src[1] toggles low then high.
